board_tracker: RTL and testbench
================================

Name: board_tracker

Overview:
- Scene-progression controller that produces the 3-bit `board_controller` offset consumed by the background render stage.
- Tracks which arena screen is shown (offset −2..+2 from centre, two's complement).
- Advances the screen when the player holding right-of-way stays at the far screen edge, then runs a timed blanking transition and requests a player respawn.
- Declares the winner when a player exits the last screen.

Parameters:
- SCREEN_W, 1024, visible width in pixels.
- EDGE_MARGIN, 16, edge zone width in pixels.
- HOLD_FRAMES, 4, consecutive frames a player must stay in the edge zone before advancing.
- TRANS_FRAMES, 30, frames of blanking per screen change.
- MAX_BOARD, 2, largest absolute board offset.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- vsync_in  in  1  VGA vsync from timing generator; its rising edge is the frame tick
- xpos_p1  in  12  player 1 x position, unsigned pixels
- xpos_p2  in  12  player 2 x position, unsigned pixels
- p1_alive  in  1  player 1 alive
- p2_alive  in  1  player 2 alive
- advantage  in  2  right-of-way: 01 = P1 (moves +), 10 = P2 (moves −), 00/11 = none
- restart  in  1  level-sensitive; return to centre and clear winner
- board_controller  out  3  signed board offset −2..+2 to the render stage
- blank_out  out  1  high during a transition; the mixer forces black
- respawn  out  1  one-cycle pulse when a transition ends
- winner  out  2  sticky: 01 = P1 won, 10 = P2 won, 00 = none
- state_dbg  out  2  current FSM state encoding

Behaviour:
- Reset and clock: clock clk; reset is synchronous, active-high, and has priority over everything.
- Reset values:
  - board_controller = 3'b000
  - blank_out = 0
  - respawn = 0
  - winner = 00
  - state = PLAY
  - hold and trans counters = 0
  - vsync_d = 0
- Frame tick: `tick = vsync_in & ~vsync_d`, where vsync_d is vsync_in registered once. Every FSM decision happens only on a tick cycle; tick is high for exactly one clk cycle per frame.
- Edge conditions, evaluated on tick:
  - e1 = p1_alive & advantage==01 & xpos_p1 >= SCREEN_W−EDGE_MARGIN
  - e2 = p2_alive & advantage==10 & xpos_p2 < EDGE_MARGIN
  - e1 and e2 are mutually exclusive by construction.
- State PLAY (00):
  - On tick, if e1 or e2: increment hold_cnt. Otherwise clear hold_cnt.
  - When the increment would reach HOLD_FRAMES, go to EDGE.
- State EDGE (01), single-tick decision state:
  - On the next tick, re-check the condition; if it has dropped, return to PLAY with hold_cnt=0.
  - If e1 and board_controller == +MAX_BOARD: winner <= 01, go to WIN.
  - If e2 and board_controller == −MAX_BOARD: winner <= 10, go to WIN.
  - Otherwise: board_controller <= board_controller +1 (e1) or −1 (e2), using signed 3-bit arithmetic; go to TRANS with trans_cnt=0 and blank_out <= 1 in the same cycle.
- State TRANS (10):
  - trans_cnt increments on each tick.
  - On the tick where trans_cnt == TRANS_FRAMES−1: blank_out <= 0, respawn <= 1 for exactly one clk, hold_cnt <= 0, go to PLAY.
  - Edge inputs are ignored during TRANS.
- State WIN (11):
  - board_controller frozen; blank_out = 0; respawn = 0.
  - Stays until restart or reset.
- restart in any state, checked on any clk (not only tick) and taking priority over the FSM:
  - board_controller <= 0, winner <= 00, blank_out <= 0, counters cleared, state <= PLAY.
  - respawn pulses once on the following cycle.
- Range invariant: board_controller is never outside −MAX_BOARD..+MAX_BOARD. Legal codes are 110, 111, 000, 001, 010; 3'b011 and 3'b100 never appear.
- Timing:
  - board_controller changes in the cycle after the EDGE decision tick, which lies in vblank, so the render stage never sees a mid-frame change.
  - Output latency from a qualifying tick is 1 clk.
- Counter widths: hold_cnt and trans_cnt are sized with $clog2 of their parameter; no wrap is possible because they are cleared on exit.
- advantage == 11 is treated as no right-of-way; neither e1 nor e2 can assert.

Test Plan:
- Reset held 2 cycles, then 10 frames of idle inputs -> board_controller=000, blank_out=0, winner=00, state_dbg=00.
- advantage=01, p1_alive=1, xpos_p1=1010 held -> EDGE on tick 4, board_controller=001 one clk after tick 5, blank_out high for exactly 30 ticks, single respawn pulse at its end.
- advantage=10, xpos_p2=5, but xpos_p2 moves to 100 on tick 3 -> hold_cnt clears, no board change, blank_out stays 0.
- From board 010, P1 held at xpos 1015 with advantage 01 -> winner=01, state_dbg=11, board stays 010; further edge stimulus has no effect. Repeat from 110 with P2 at x=0 -> winner=10.
- restart asserted mid-TRANS at trans_cnt=12 -> next cycle board_controller=000, blank_out=0, state PLAY; respawn pulse on the following cycle.
- advantage=11 with both players in their edge zones for 20 frames -> no transition. Reset asserted during EDGE -> all outputs return to reset values in one cycle.

Source files
------------

// File: rtl/board_tracker_if.sv
// Player/frame inputs and render-stage outputs of the board tracker.
// master drives the player state and frame timing; slave is the tracker.
interface board_tracker_if;
    logic        vsync_in;
    logic [11:0] xpos_p1;
    logic [11:0] xpos_p2;
    logic        p1_alive;
    logic        p2_alive;
    logic [1:0]  advantage;
    logic        restart;
    logic [2:0]  board_controller;
    logic        blank_out;
    logic        respawn;
    logic [1:0]  winner;
    logic [1:0]  state_dbg;

    modport master (
        output vsync_in, xpos_p1, xpos_p2, p1_alive, p2_alive, advantage, restart,
        input  board_controller, blank_out, respawn, winner, state_dbg
    );

    modport slave (
        input  vsync_in, xpos_p1, xpos_p2, p1_alive, p2_alive, advantage, restart,
        output board_controller, blank_out, respawn, winner, state_dbg
    );
endinterface

// File: rtl/board_tracker.sv
// Scene-progression FSM: screen offset, blanking transition, respawn and winner.
// Outputs are registered, 1 clk after the qualifying frame tick; no backpressure.
module board_tracker #(
    parameter int SCREEN_W     = 1024,
    parameter int EDGE_MARGIN  = 16,
    parameter int HOLD_FRAMES  = 4,
    parameter int TRANS_FRAMES = 30,
    parameter int MAX_BOARD    = 2
) (
    input logic            clk,
    input logic            reset,
    board_tracker_if.slave bus
);
    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        EDGE  = 2'b01,
        TRANS = 2'b10,
        WIN   = 2'b11
    } state_t;

    localparam int HW = (HOLD_FRAMES  > 2) ? $clog2(HOLD_FRAMES)  : 1;
    localparam int TW = (TRANS_FRAMES > 2) ? $clog2(TRANS_FRAMES) : 1;

    localparam logic [11:0]       RIGHT_EDGE = 12'(SCREEN_W - EDGE_MARGIN);
    localparam logic [11:0]       LEFT_EDGE  = 12'(EDGE_MARGIN);
    localparam logic [HW:0]       HOLD_LAST  = (HW+1)'(HOLD_FRAMES);
    localparam logic [TW-1:0]     TRANS_LAST = TW'(TRANS_FRAMES - 1);
    localparam logic signed [2:0] MAXB       = 3'(MAX_BOARD);
    localparam logic signed [2:0] MINB       = -MAXB;

    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic [TW-1:0]     trans_cnt;
    logic signed [2:0] board;
    logic              blank;
    logic              respawn_q;
    logic [1:0]        winner_q;
    logic              vsync_d;
    logic              restart_q;
    logic              restart_qq;

    logic        tick;
    logic        e1;
    logic        e2;
    logic [HW:0] hold_nxt;

    assign tick     = bus.vsync_in & ~vsync_d;
    assign e1       = bus.p1_alive & (bus.advantage == 2'b01) & (bus.xpos_p1 >= RIGHT_EDGE);
    assign e2       = bus.p2_alive & (bus.advantage == 2'b10) & (bus.xpos_p2 <  LEFT_EDGE);
    assign hold_nxt = {1'b0, hold_cnt} + (HW+1)'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PLAY;
            hold_cnt   <= '0;
            trans_cnt  <= '0;
            board      <= '0;
            blank      <= 1'b0;
            respawn_q  <= 1'b0;
            winner_q   <= 2'b00;
            vsync_d    <= 1'b0;
            restart_q  <= 1'b0;
            restart_qq <= 1'b0;
        end else begin
            vsync_d    <= bus.vsync_in;
            restart_q  <= bus.restart;
            restart_qq <= restart_q;
            // Restart's respawn lands one cycle after the board snaps to centre.
            respawn_q  <= restart_q & ~restart_qq;

            if (bus.restart) begin
                state     <= PLAY;
                hold_cnt  <= '0;
                trans_cnt <= '0;
                board     <= '0;
                blank     <= 1'b0;
                winner_q  <= 2'b00;
            end else if (tick) begin
                case (state)
                    PLAY: begin
                        if (e1 | e2) begin
                            if (hold_nxt == HOLD_LAST) begin
                                state    <= EDGE;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_nxt[HW-1:0];
                            end
                        end else begin
                            hold_cnt <= '0;
                        end
                    end
                    EDGE: begin
                        if (!(e1 | e2)) begin
                            state    <= PLAY;
                            hold_cnt <= '0;
                        end else if (e1 && board == MAXB) begin
                            winner_q <= 2'b01;
                            state    <= WIN;
                        end else if (e2 && board == MINB) begin
                            winner_q <= 2'b10;
                            state    <= WIN;
                        end else begin
                            board     <= e1 ? board + 3'sd1 : board - 3'sd1;
                            trans_cnt <= '0;
                            blank     <= 1'b1;
                            state     <= TRANS;
                        end
                    end
                    TRANS: begin
                        if (trans_cnt == TRANS_LAST) begin
                            blank     <= 1'b0;
                            respawn_q <= 1'b1;
                            hold_cnt  <= '0;
                            trans_cnt <= '0;
                            state     <= PLAY;
                        end else begin
                            trans_cnt <= trans_cnt + TW'(1);
                        end
                    end
                    default: begin
                        state <= WIN;
                    end
                endcase
            end
        end
    end

    assign bus.board_controller = board;
    assign bus.blank_out        = blank;
    assign bus.respawn          = respawn_q;
    assign bus.winner           = winner_q;
    assign bus.state_dbg        = state;
endmodule

// File: tb/tb_board_tracker.sv
// Randomized and directed bench for board_tracker against a frame-level reference model.
module tb_board_tracker;
    localparam int SCREEN_W     = 1024;
    localparam int EDGE_MARGIN  = 16;
    localparam int HOLD_FRAMES  = 4;
    localparam int TRANS_FRAMES = 30;
    localparam int MAX_BOARD    = 2;
    localparam int FRAME_LEN    = 6;

    logic clk;
    logic reset;
    board_tracker_if bif();

    board_tracker #(
        .SCREEN_W     (SCREEN_W),
        .EDGE_MARGIN  (EDGE_MARGIN),
        .HOLD_FRAMES  (HOLD_FRAMES),
        .TRANS_FRAMES (TRANS_FRAMES),
        .MAX_BOARD    (MAX_BOARD)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int resp_seen = 0;

    // Reference model: phase 0 play, 1 edge decision, 2 blanking, 3 won.
    int m_phase = 0;
    int m_hold = 0;
    int m_frames = 0;
    int m_board = 0;
    int m_winner = 0;
    bit m_blank = 0;
    bit m_vsd = 0;
    bit m_rq = 0;
    bit m_rqq = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit tick, e1, e2, exp_resp, legal;
        @(posedge clk);
        #1;
        tick = bif.vsync_in && !m_vsd;
        m_vsd = bif.vsync_in;
        exp_resp = 1'b0;
        if (reset) begin
            m_phase = 0; m_hold = 0; m_frames = 0; m_board = 0;
            m_winner = 0; m_blank = 0; m_vsd = 0; m_rq = 0; m_rqq = 0;
        end else begin
            exp_resp = m_rq && !m_rqq;
            m_rqq = m_rq;
            m_rq = bif.restart;
            e1 = bif.p1_alive && bif.advantage == 2'b01 && int'(bif.xpos_p1) >= SCREEN_W - EDGE_MARGIN;
            e2 = bif.p2_alive && bif.advantage == 2'b10 && int'(bif.xpos_p2) < EDGE_MARGIN;
            if (bif.restart) begin
                m_phase = 0; m_hold = 0; m_frames = 0; m_board = 0; m_winner = 0; m_blank = 0;
            end else if (tick) begin
                case (m_phase)
                    0: begin
                        if (e1 || e2) begin
                            m_hold++;
                            if (m_hold == HOLD_FRAMES) begin m_phase = 1; m_hold = 0; end
                        end else m_hold = 0;
                    end
                    1: begin
                        if (!(e1 || e2)) begin m_phase = 0; m_hold = 0; end
                        else if (e1 && m_board == MAX_BOARD) begin m_winner = 1; m_phase = 3; end
                        else if (e2 && m_board == -MAX_BOARD) begin m_winner = 2; m_phase = 3; end
                        else begin
                            m_board = m_board + (e1 ? 1 : -1);
                            m_phase = 2; m_blank = 1; m_frames = 0;
                        end
                    end
                    2: begin
                        m_frames++;
                        if (m_frames == TRANS_FRAMES) begin
                            m_blank = 0; exp_resp = 1'b1; m_hold = 0; m_phase = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (bif.respawn === 1'b1) resp_seen++;
        legal = (bif.board_controller != 3'b011) && (bif.board_controller != 3'b100);
        chk("board",   32'(bif.board_controller), 32'(m_board & 7));
        chk("blank",   32'(bif.blank_out),        32'(m_blank));
        chk("respawn", 32'(bif.respawn),          32'(exp_resp));
        chk("winner",  32'(bif.winner),           32'(m_winner));
        chk("state",   32'(bif.state_dbg),        32'(m_phase));
        chk("range",   32'(legal),                32'd1);
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < FRAME_LEN; c++) begin
                bif.vsync_in = (c < 2);
                step();
            end
        end
    endtask

    task automatic pulse_restart();
        bif.restart = 1'b1;
        step();
        bif.restart = 1'b0;
    endtask

    task automatic idle_inputs();
        bif.advantage = 2'b00;
        bif.xpos_p1   = 12'd500;
        bif.xpos_p2   = 12'd500;
        bif.p1_alive  = 1'b1;
        bif.p2_alive  = 1'b1;
    endtask

    function automatic logic [11:0] rand_x();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)      return 12'($urandom_range(SCREEN_W - EDGE_MARGIN, 4095));
        else if (r < 8) return 12'($urandom_range(0, EDGE_MARGIN - 1));
        else            return 12'($urandom_range(0, 4095));
    endfunction

    initial begin
        int r0;
        reset = 1'b1;
        bif.vsync_in = 1'b0;
        bif.restart  = 1'b0;
        idle_inputs();

        step();
        step();
        reset = 1'b0;
        frames(10);
        chk("idle_board", 32'(bif.board_controller), 32'd0);
        chk("idle_state", 32'(bif.state_dbg), 32'd0);

        // P1 holds the right edge: EDGE on tick 4, board +1 after tick 5, 30 blank ticks.
        bif.advantage = 2'b01;
        bif.xpos_p1   = 12'd1010;
        frames(3);
        chk("pre_edge_state", 32'(bif.state_dbg), 32'd0);
        frames(1);
        chk("edge_tick4", 32'(bif.state_dbg), 32'd1);
        frames(1);
        chk("adv_board", 32'(bif.board_controller), 32'd1);
        chk("adv_blank", 32'(bif.blank_out), 32'd1);
        r0 = resp_seen;
        frames(TRANS_FRAMES - 1);
        chk("blank_hold", 32'(bif.blank_out), 32'd1);
        bif.advantage = 2'b00;
        frames(1);
        chk("blank_end", 32'(bif.blank_out), 32'd0);
        chk("one_respawn", 32'(resp_seen - r0), 32'd1);

        // P2 leaves the edge zone on tick 3: no change.
        bif.advantage = 2'b10;
        bif.xpos_p2   = 12'd5;
        frames(2);
        bif.xpos_p2   = 12'd100;
        frames(3);
        chk("abort_board", 32'(bif.board_controller), 32'd1);
        chk("abort_blank", 32'(bif.blank_out), 32'd0);

        // P1 wins from the far right screen.
        bif.advantage = 2'b01;
        bif.xpos_p1   = 12'd1015;
        frames(45);
        chk("p1_win", 32'(bif.winner), 32'd1);
        chk("p1_win_state", 32'(bif.state_dbg), 32'd3);
        chk("p1_win_board", 32'(bif.board_controller), 32'd2);
        frames(10);
        chk("win_frozen", 32'(bif.board_controller), 32'd2);

        // P2 wins from the far left screen.
        pulse_restart();
        bif.advantage = 2'b10;
        bif.xpos_p2   = 12'd0;
        frames(2 * (HOLD_FRAMES + 1 + TRANS_FRAMES) + 10);
        chk("p2_win", 32'(bif.winner), 32'd2);
        chk("p2_win_board", 32'(bif.board_controller), 32'b110);

        // Restart in the middle of a transition at trans_cnt = 12.
        pulse_restart();
        bif.advantage = 2'b01;
        bif.xpos_p1   = 12'd1010;
        frames(HOLD_FRAMES + 1);
        bif.advantage = 2'b00;
        frames(12);
        chk("mid_trans_blank", 32'(bif.blank_out), 32'd1);
        bif.vsync_in = 1'b0;
        pulse_restart();
        chk("rst_mid_board", 32'(bif.board_controller), 32'd0);
        chk("rst_mid_blank", 32'(bif.blank_out), 32'd0);
        chk("rst_mid_state", 32'(bif.state_dbg), 32'd0);
        step();
        chk("rst_mid_respawn", 32'(bif.respawn), 32'd1);

        // advantage 11 with both players in their edge zones.
        bif.advantage = 2'b11;
        bif.xpos_p1   = 12'd1020;
        bif.xpos_p2   = 12'd3;
        frames(20);
        chk("adv11_state", 32'(bif.state_dbg), 32'd0);
        chk("adv11_blank", 32'(bif.blank_out), 32'd0);

        // Reset while in EDGE.
        bif.advantage = 2'b01;
        frames(HOLD_FRAMES);
        chk("edge_before_reset", 32'(bif.state_dbg), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_edge_state", 32'(bif.state_dbg), 32'd0);
        chk("reset_edge_board", 32'(bif.board_controller), 32'd0);

        // Randomized segments of stable player input with rare restart/reset.
        for (int s = 0; s < 400; s++) begin
            int nf;
            r0 = $urandom_range(0, 9);
            bif.advantage = (r0 < 4) ? 2'b01 : (r0 < 8) ? 2'b10 : 2'($urandom_range(0, 3));
            bif.xpos_p1   = rand_x();
            bif.xpos_p2   = rand_x();
            bif.p1_alive  = ($urandom_range(0, 9) != 0);
            bif.p2_alive  = ($urandom_range(0, 9) != 0);
            nf = $urandom_range(1, 12);
            for (int f = 0; f < nf; f++) begin
                for (int c = 0; c < FRAME_LEN; c++) begin
                    bif.vsync_in = (c < 2);
                    bif.restart  = ($urandom_range(0, 299) == 0);
                    reset        = ($urandom_range(0, 999) == 0);
                    step();
                    bif.restart  = 1'b0;
                    reset        = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
